// File: rtl/pc_stack_counter.sv
// Program counter with relative branch and a call/return stack.
// Drives the instruction memory address bus from controller strobes.
module pc_stack_counter #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int OFF_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              branch,
  input  logic [OFF_W-1:0]  offset,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0]       stk [DEPTH];
  logic [CW-1:0]           cnt;
  logic [ADDR_W-1:0]       pc_inc;
  logic [ADDR_W-1:0]       pc_br;
  logic [ADDR_W-1:0]       top;
  logic [ADDR_W+OFF_W-1:0] off_ext;
  logic                    pc_max;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign pc_inc  = pc + ADDR_W'(1);
  assign pc_max  = (pc == '1);
  assign off_ext = {{ADDR_W{offset[OFF_W-1]}}, offset};
  assign pc_br   = pc + off_ext[ADDR_W-1:0];
  assign top     = stk[IW'(cnt - CW'(1))];

  // Only the winning strobe may touch the stack.
  assign do_push = !load && call && !full;
  assign do_pop  = !load && !call && ret && !empty;

  always_ff @(posedge clk) begin
    if (do_push) stk[IW'(cnt)] <= pc_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        pc <= addr_in;
      end else if (call) begin
        if (full) begin
          err <= 1'b1;
        end else begin
          pc   <= addr_in;
          cnt  <= cnt + CW'(1);
          wrap <= pc_max;
        end
      end else if (ret) begin
        if (empty) begin
          err <= 1'b1;
        end else begin
          pc  <= top;
          cnt <= cnt - CW'(1);
        end
      end else if (branch) begin
        pc <= pc_br;
      end else if (inc) begin
        pc   <= pc_inc;
        wrap <= pc_max;
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_counter.sv
// Directed bench for pc_stack_counter at ADDR_W=5, DEPTH=4, OFF_W=5.
module tb_pc_stack_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc = 1'b0;
  logic       load = 1'b0;
  logic [4:0] addr_in = '0;
  logic       branch = 1'b0;
  logic [4:0] offset = '0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [4:0] pc;
  logic       wrap;
  logic       full;
  logic       empty;
  logic       err;

  int checks = 0;
  int errors = 0;

  pc_stack_counter #(.ADDR_W(5), .DEPTH(4), .OFF_W(5)) dut (
    .clk(clk), .rst(rst), .inc(inc), .load(load),
    .addr_in(addr_in), .branch(branch), .offset(offset),
    .call(call), .ret(ret), .pc(pc), .wrap(wrap),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    inc = 0; load = 0; branch = 0; call = 0; ret = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    #3;
    rst = 0;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #3;
    checks++;
    if (pc !== 5'h00 || empty !== 1 || full !== 0 || err !== 0 || wrap !== 0) begin
      errors++;
      $display("FAIL reset: pc=%h e=%b f=%b err=%b w=%b want 00 1 0 0 0",
               pc, empty, full, err, wrap);
    end
    rst = 0;
    repeat (3) step();
    checks++;
    if (pc !== 5'h00) begin
      errors++;
      $display("FAIL reset_idle: pc=%h want 00", pc);
    end
  endtask

  task automatic test_load_inc();
    logic [4:0] exp_pc [5] = '{5'h1E, 5'h1F, 5'h00, 5'h01, 5'h02};
    logic       exp_w  [5] = '{0, 0, 1, 0, 0};
    load = 1; addr_in = 5'h1D;
    step();
    load = 0;
    checks++;
    if (pc !== 5'h1D) begin
      errors++;
      $display("FAIL load: pc=%h want 1d", pc);
    end
    inc = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pc !== exp_pc[i] || wrap !== exp_w[i]) begin
        errors++;
        $display("FAIL inc%0d: pc=%h wrap=%b want %h %b",
                 i, pc, wrap, exp_pc[i], exp_w[i]);
      end
    end
    inc = 0;
    step();
    checks++;
    if (pc !== 5'h02 || wrap !== 0) begin
      errors++;
      $display("FAIL hold: pc=%h wrap=%b want 02 0", pc, wrap);
    end
  endtask

  task automatic test_branch();
    branch = 1; offset = 5'b11101;
    step();
    checks++;
    if (pc !== 5'h1F || wrap !== 0) begin
      errors++;
      $display("FAIL branch_neg: pc=%h wrap=%b want 1f 0", pc, wrap);
    end
    offset = 5'b00100;
    step();
    branch = 0;
    checks++;
    if (pc !== 5'h03 || wrap !== 0) begin
      errors++;
      $display("FAIL branch_pos: pc=%h wrap=%b want 03 0", pc, wrap);
    end
  endtask

  task automatic test_call_ret();
    logic [4:0] tgt [4] = '{5'h10, 5'h11, 5'h12, 5'h13};
    logic [4:0] rpc [4] = '{5'h13, 5'h12, 5'h11, 5'h04};
    call = 1;
    for (int i = 0; i < 4; i++) begin
      addr_in = tgt[i];
      step();
      checks++;
      if (pc !== tgt[i] || empty !== 0) begin
        errors++;
        $display("FAIL call%0d: pc=%h empty=%b want %h 0", i, pc, empty, tgt[i]);
      end
    end
    checks++;
    if (full !== 1 || err !== 0) begin
      errors++;
      $display("FAIL full: full=%b err=%b want 1 0", full, err);
    end
    addr_in = 5'h08;
    step();
    call = 0;
    checks++;
    if (pc !== 5'h13 || err !== 1 || full !== 1) begin
      errors++;
      $display("FAIL call_full: pc=%h err=%b full=%b want 13 1 1", pc, err, full);
    end
    ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pc !== rpc[i] || full !== 0) begin
        errors++;
        $display("FAIL ret%0d: pc=%h full=%b want %h 0", i, pc, full, rpc[i]);
      end
    end
    ret = 0;
    checks++;
    if (empty !== 1 || err !== 1) begin
      errors++;
      $display("FAIL after_ret: empty=%b err=%b want 1 1", empty, err);
    end
  endtask

  task automatic test_ret_empty();
    do_reset();
    ret = 1;
    step();
    ret = 0;
    checks++;
    if (pc !== 5'h00 || err !== 1 || empty !== 1) begin
      errors++;
      $display("FAIL ret_empty: pc=%h err=%b empty=%b want 00 1 1", pc, err, empty);
    end
    inc = 1;
    step();
    inc = 0;
    checks++;
    if (pc !== 5'h01 || err !== 1) begin
      errors++;
      $display("FAIL err_sticky: pc=%h err=%b want 01 1", pc, err);
    end
  endtask

  task automatic test_priority();
    load = 1; call = 1; inc = 1; addr_in = 5'h0A;
    step();
    idle();
    checks++;
    if (pc !== 5'h0A || empty !== 1) begin
      errors++;
      $display("FAIL prio_load: pc=%h empty=%b want 0a 1", pc, empty);
    end
    call = 1; ret = 1; addr_in = 5'h15;
    step();
    idle();
    checks++;
    if (pc !== 5'h15 || empty !== 0) begin
      errors++;
      $display("FAIL prio_call: pc=%h empty=%b want 15 0", pc, empty);
    end
    ret = 1; branch = 1; inc = 1; offset = 5'b00011;
    step();
    idle();
    checks++;
    if (pc !== 5'h0B || empty !== 1) begin
      errors++;
      $display("FAIL prio_ret: pc=%h empty=%b want 0b 1", pc, empty);
    end
    branch = 1; inc = 1; offset = 5'b00011;
    step();
    idle();
    checks++;
    if (pc !== 5'h0E) begin
      errors++;
      $display("FAIL prio_branch: pc=%h want 0e", pc);
    end
  endtask

  task automatic test_async_reset();
    call = 1; addr_in = 5'h05;
    step();
    addr_in = 5'h09;
    step();
    idle();
    checks++;
    if (pc !== 5'h09 || empty !== 0 || err !== 1) begin
      errors++;
      $display("FAIL pre_areset: pc=%h empty=%b err=%b want 09 0 1", pc, empty, err);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if (pc !== 5'h00 || empty !== 1 || err !== 0 || full !== 0) begin
      errors++;
      $display("FAIL areset: pc=%h empty=%b err=%b full=%b want 00 1 0 0",
               pc, empty, err, full);
    end
    #2;
    rst = 0;
    step();
    checks++;
    if (pc !== 5'h00 || empty !== 1) begin
      errors++;
      $display("FAIL post_areset: pc=%h empty=%b want 00 1", pc, empty);
    end
  endtask

  initial begin
    test_reset();
    test_load_inc();
    test_branch();
    test_call_ret();
    test_ret_empty();
    test_priority();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
